alu_control_unit: RTL and testbench

ALU_CONTROL_UNIT -- requirements
Module: alu_control

---
 rtl/alu_control_unit.sv | 63 ++++++
 tb/tb_alu_control_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_control_unit.sv
// ALU control decoder: turns the main-decoder operation class plus funct into
// an ALU control code, available combinationally and as a registered copy.
module alu_control_unit #(
  parameter logic [3:0] ILLEGAL_CODE = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] aluctl,
  output logic       illegal,
  output logic [3:0] aluctl_q,
  output logic       illegal_q
);

  logic [3:0] w_aluctl;
  logic       w_illegal;
  logic [3:0] r_aluctl;
  logic       r_illegal;

  // Full 6-bit funct match: upper-bit patterns fall to the illegal default
  // rather than aliasing onto codes 0..6.
  always_comb begin
    w_aluctl  = 4'd2;
    w_illegal = 1'b0;
    case (aluop)
      2'd0:    w_aluctl = 4'd2;
      2'd1:    w_aluctl = 4'd6;
      2'd2: begin
        case (funct)
          6'd0:    w_aluctl = 4'd2;
          6'd1:    w_aluctl = 4'd6;
          6'd2:    w_aluctl = 4'd0;
          6'd3:    w_aluctl = 4'd12;
          6'd4:    w_aluctl = 4'd1;
          6'd5:    w_aluctl = 4'd7;
          6'd6:    w_aluctl = 4'd13;
          default: begin
            w_aluctl  = ILLEGAL_CODE;
            w_illegal = 1'b1;
          end
        endcase
      end
      default: w_aluctl = 4'd2;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aluctl  <= 4'd0;
      r_illegal <= 1'b0;
    end else begin
      r_aluctl  <= w_aluctl;
      r_illegal <= w_illegal;
    end
  end

  assign aluctl    = w_aluctl;
  assign illegal   = w_illegal;
  assign aluctl_q  = r_aluctl;
  assign illegal_q = r_illegal;

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit: combinational decode table, illegal
// detection, registered latency and asynchronous reset behaviour.
module tb_alu_control_unit;

  logic       clk;
  logic       rst_n;
  logic [1:0] aluop;
  logic [5:0] funct;
  logic [3:0] aluctl;
  logic       illegal;
  logic [3:0] aluctl_q;
  logic       illegal_q;

  int n_tests = 0;
  int n_fail  = 0;

  alu_control_unit #(.ILLEGAL_CODE(4'hF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .aluop    (aluop),
    .funct    (funct),
    .aluctl   (aluctl),
    .illegal  (illegal),
    .aluctl_q (aluctl_q),
    .illegal_q(illegal_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_tab [7];

  initial begin
    exp_tab = '{4'd2, 4'd6, 4'd0, 4'd12, 4'd1, 4'd7, 4'd13};
    rst_n = 1'b0;
    aluop = 2'd0;
    funct = 6'd0;
    #1;
    chk("reset_aluctl_q", aluctl_q, 4'd0);
    chk("reset_illegal_q", {3'b0, illegal_q}, 4'd0);

    // Registers hold zero across edges in reset; decode stays live
    @(negedge clk);
    aluop = 2'd2; funct = 6'd63;
    @(posedge clk); #1;
    chk("rst_hold_aluctl_q", aluctl_q, 4'd0);
    chk("rst_hold_illegal_q", {3'b0, illegal_q}, 4'd0);
    chk("rst_comb_aluctl", aluctl, 4'hF);
    chk("rst_comb_illegal", {3'b0, illegal}, 4'd1);

    @(negedge clk);
    rst_n = 1'b1;

    // Non-R-type classes ignore funct
    aluop = 2'd0; funct = 6'd3; #1;
    chk("op0_f3_aluctl", aluctl, 4'd2);
    chk("op0_f3_illegal", {3'b0, illegal}, 4'd0);
    aluop = 2'd1; funct = 6'd5; #1;
    chk("op1_f5_aluctl", aluctl, 4'd6);
    chk("op1_f5_illegal", {3'b0, illegal}, 4'd0);
    aluop = 2'd3; funct = 6'd1; #1;
    chk("op3_f1_aluctl", aluctl, 4'd2);
    aluop = 2'd0; funct = 6'd63; #1;
    chk("op0_f63_aluctl", aluctl, 4'd2);
    chk("op0_f63_illegal", {3'b0, illegal}, 4'd0);
    aluop = 2'd1; funct = 6'd40; #1;
    chk("op1_f40_illegal", {3'b0, illegal}, 4'd0);

    aluop = 2'd2;
    for (int i = 0; i < 7; i++) begin
      funct = 6'(i); #1;
      chk($sformatf("rtype_f%0d_aluctl", i), aluctl, exp_tab[i]);
      chk($sformatf("rtype_f%0d_illegal", i), {3'b0, illegal}, 4'd0);
    end
    funct = 6'd7; #1;
    chk("rtype_f7_aluctl", aluctl, 4'hF);
    chk("rtype_f7_illegal", {3'b0, illegal}, 4'd1);
    funct = 6'd63; #1;
    chk("rtype_f63_aluctl", aluctl, 4'hF);
    chk("rtype_f63_illegal", {3'b0, illegal}, 4'd1);
    funct = 6'd33; #1;
    chk("rtype_f33_aluctl", aluctl, 4'hF);
    chk("rtype_f33_illegal", {3'b0, illegal}, 4'd1);
    funct = 6'd34; #1;
    chk("rtype_f34_aluctl", aluctl, 4'hF);

    // One-cycle register latency
    @(negedge clk);
    aluop = 2'd1; funct = 6'd0;
    @(posedge clk); #1;
    chk("q_sub_aluctl_q", aluctl_q, 4'd6);
    @(negedge clk);
    aluop = 2'd2; funct = 6'd5; #1;
    chk("q_before_edge_aluctl_q", aluctl_q, 4'd6);
    chk("q_before_edge_aluctl", aluctl, 4'd7);
    @(posedge clk); #1;
    chk("q_slt_aluctl_q", aluctl_q, 4'd7);
    chk("q_slt_illegal_q", {3'b0, illegal_q}, 4'd0);

    @(negedge clk);
    funct = 6'd33;
    @(posedge clk); #1;
    chk("q_ill_aluctl_q", aluctl_q, 4'hF);
    chk("q_ill_illegal_q", {3'b0, illegal_q}, 4'd1);

    // Async reset mid-cycle, then recovery
    @(negedge clk);
    funct = 6'd6;
    @(posedge clk); #1;
    chk("q_f6_aluctl_q", aluctl_q, 4'd13);
    chk("q_f6_illegal_q", {3'b0, illegal_q}, 4'd0);
    #2;
    rst_n = 1'b0; #1;
    chk("async_rst_aluctl_q", aluctl_q, 4'd0);
    chk("async_rst_illegal_q", {3'b0, illegal_q}, 4'd0);
    chk("async_rst_comb", aluctl, 4'd13);
    @(posedge clk); #1;
    chk("async_rst_hold", aluctl_q, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    aluop = 2'd1; #1;
    chk("release_before_edge", aluctl_q, 4'd0);
    @(posedge clk); #1;
    chk("release_first_edge", aluctl_q, 4'd6);
    chk("release_illegal_q", {3'b0, illegal_q}, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
